// File: rtl/key_digit_counter.sv
// Hex digit counter driven by four debounced active-low push-buttons.
// Keys: increment, decrement, clear, and a hold level that blocks counting.
module key_digit_counter #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] KEY,
    output logic [3:0] DIGIT,
    output logic       DIGIT_STB,
    output logic [9:0] LEDR
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    stable;
    logic [3:0]    stable_next;
    logic [3:0]    stable_d;
    logic [CW-1:0] cnt      [4];
    logic [CW-1:0] cnt_next [4];

    logic [3:0] press;
    logic       inc_ev;
    logic       dec_ev;
    logic       clr_ev;
    logic       held;
    logic       wrap;
    logic [3:0] digit_next;
    logic       wrap_next;
    logic       stb_next;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    // Stable level flips on the last of an unbroken run of mismatches.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < 4; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == LAST) begin
                    stable_next[i] = ~stable[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            stable   <= '1;
            stable_d <= '1;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable   <= stable_next;
            stable_d <= stable;
            cnt      <= cnt_next;
        end
    end

    assign press  = stable_d & ~stable;
    assign inc_ev = press[0];
    assign dec_ev = press[1];
    assign clr_ev = press[2];
    assign held   = ~stable[3];

    always_comb begin
        digit_next = DIGIT;
        wrap_next  = wrap;
        stb_next   = 1'b0;
        if (clr_ev) begin
            digit_next = 4'h0;
            wrap_next  = 1'b0;
            stb_next   = 1'b1;
        end else if (!held && (inc_ev ^ dec_ev)) begin
            stb_next = 1'b1;
            if (inc_ev) begin
                digit_next = DIGIT + 4'd1;
                wrap_next  = wrap | (DIGIT == 4'hF);
            end else begin
                digit_next = DIGIT - 4'd1;
                wrap_next  = wrap | (DIGIT == 4'h0);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            DIGIT     <= 4'h0;
            DIGIT_STB <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            DIGIT     <= digit_next;
            DIGIT_STB <= stb_next;
            wrap      <= wrap_next;
        end
    end

    assign LEDR = {1'b0, wrap, ~stable, DIGIT};

endmodule

// File: tb/tb_key_digit_counter.sv
// Self-checking bench for key_digit_counter with a short debounce window.
// Directed scenarios plus randomized key activity against a behavioural model.
module tb_key_digit_counter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [3:0] digit;
    logic       digit_stb;
    logic [9:0] ledr;

    int n_checks = 0;
    int n_fail   = 0;

    key_digit_counter #(.DEBOUNCE_CYCLES(N)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .KEY      (key),
        .DIGIT    (digit),
        .DIGIT_STB(digit_stb),
        .LEDR     (ledr)
    );

    always #5 clk = ~clk;

    // Reference model: a key is accepted once its last N synchronized
    // samples all disagree with the accepted level.
    logic [3:0] m_s1, m_s2, m_acc, m_prev;
    logic       hist [4][N];
    logic [3:0] m_digit;
    logic       m_stb, m_wrap;
    logic [9:0] m_ledr;

    always @(posedge clk) begin
        logic [3:0] pr;
        logic       all_diff;
        int         d;
        if (rst) begin
            m_s1 = '1; m_s2 = '1; m_acc = '1; m_prev = '1;
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < N; k++) hist[i][k] = 1'b1;
            m_digit = 0; m_stb = 0; m_wrap = 0;
        end else begin
            pr = m_prev & ~m_acc;
            m_stb = 0;
            if (pr[2]) begin
                m_digit = 0; m_wrap = 0; m_stb = 1;
            end else if (m_acc[3] && (pr[0] != pr[1])) begin
                d = int'(m_digit) + (pr[0] ? 1 : -1);
                if (d < 0 || d > 15) m_wrap = 1;
                m_digit = 4'((d + 16) % 16);
                m_stb = 1;
            end
            m_prev = m_acc;
            for (int i = 0; i < 4; i++) begin
                for (int k = N - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = m_s2[i];
                all_diff = 1;
                for (int k = 0; k < N; k++)
                    if (hist[i][k] == m_acc[i]) all_diff = 0;
                if (all_diff) m_acc[i] = ~m_acc[i];
            end
            m_s2 = m_s1;
            m_s1 = key;
        end
        m_ledr = {1'b0, m_wrap, ~m_acc, m_digit};
    end

    task automatic apply_reset();
        rst = 1; key = 4'hF;
        @(negedge clk); @(negedge clk);
        rst = 0;
    endtask

    task automatic do_press(input int idx, output int strobes);
        strobes = 0;
        key[idx] = 0;
        repeat (8) begin @(negedge clk); strobes += int'(digit_stb); end
        key[idx] = 1;
        repeat (8) begin @(negedge clk); strobes += int'(digit_stb); end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (digit !== 4'h0 || digit_stb !== 1'b0 || ledr !== 10'h000) begin
            n_fail++;
            $display("FAIL reset: digit=%h stb=%b ledr=%h, want 0 0 000", digit, digit_stb, ledr);
        end
    endtask

    task automatic test_latency();
        key[0] = 0;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            n_checks++;
            if (digit !== ((e >= 7) ? 4'h1 : 4'h0) || digit_stb !== (e == 7)
                || ledr[4] !== (e >= 6)) begin
                n_fail++;
                $display("FAIL latency e%0d: digit=%h stb=%b led4=%b", e, digit, digit_stb, ledr[4]);
            end
        end
        n_checks++;
        if (ledr[3:0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL latency_led: ledr[3:0]=%b want 0001", ledr[3:0]);
        end
        key[0] = 1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (digit !== 4'h1 || ledr[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL release: digit=%h led4=%b want 1 0", digit, ledr[4]);
        end
    endtask

    task automatic test_glitch();
        int s = 0;
        apply_reset();
        key[0] = 0;
        repeat (3) begin @(negedge clk); s += int'(digit_stb); end
        key[0] = 1;
        repeat (12) begin @(negedge clk); s += int'(digit_stb); end
        n_checks++;
        if (digit !== 4'h0 || s !== 0) begin
            n_fail++;
            $display("FAIL glitch: digit=%h strobes=%0d want 0 0", digit, s);
        end
    endtask

    task automatic test_wrap();
        int s;
        apply_reset();
        for (int k = 1; k <= 15; k++) do_press(0, s);
        n_checks++;
        if (digit !== 4'hF || ledr[8] !== 1'b0) begin
            n_fail++;
            $display("FAIL count15: digit=%h wrap=%b want F 0", digit, ledr[8]);
        end
        do_press(0, s);
        n_checks++;
        if (digit !== 4'h0 || ledr[8] !== 1'b1 || s !== 1) begin
            n_fail++;
            $display("FAIL inc_wrap: digit=%h wrap=%b stb=%0d want 0 1 1", digit, ledr[8], s);
        end
        do_press(1, s);
        n_checks++;
        if (digit !== 4'hF || ledr[8] !== 1'b1 || s !== 1) begin
            n_fail++;
            $display("FAIL dec_wrap: digit=%h wrap=%b stb=%0d want F 1 1", digit, ledr[8], s);
        end
        do_press(2, s);
        n_checks++;
        if (digit !== 4'h0 || ledr[8] !== 1'b0 || s !== 1) begin
            n_fail++;
            $display("FAIL clear: digit=%h wrap=%b stb=%0d want 0 0 1", digit, ledr[8], s);
        end
        do_press(2, s);
        n_checks++;
        if (digit !== 4'h0 || s !== 1) begin
            n_fail++;
            $display("FAIL clear_zero: digit=%h stb=%0d want 0 1", digit, s);
        end
    endtask

    task automatic test_cancel_hold();
        int s = 0;
        apply_reset();
        for (int k = 0; k < 5; k++) do_press(0, s);
        s = 0;
        key[1:0] = 2'b00;
        repeat (10) begin @(negedge clk); s += int'(digit_stb); end
        key[1:0] = 2'b11;
        repeat (10) begin @(negedge clk); s += int'(digit_stb); end
        n_checks++;
        if (digit !== 4'h5 || s !== 0) begin
            n_fail++;
            $display("FAIL cancel: digit=%h strobes=%0d want 5 0", digit, s);
        end
        key[3] = 0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (ledr[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_led: ledr[7]=%b want 1", ledr[7]);
        end
        s = 0;
        key[0] = 0;
        repeat (10) begin @(negedge clk); s += int'(digit_stb); end
        key[3] = 1;
        repeat (12) begin @(negedge clk); s += int'(digit_stb); end
        key[0] = 1;
        repeat (10) begin @(negedge clk); s += int'(digit_stb); end
        n_checks++;
        if (digit !== 4'h5 || s !== 0) begin
            n_fail++;
            $display("FAIL hold: digit=%h strobes=%0d want 5 0", digit, s);
        end
        key[3] = 0;
        repeat (8) @(negedge clk);
        do_press(2, s);
        key[3] = 1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (digit !== 4'h0 || s !== 1) begin
            n_fail++;
            $display("FAIL clear_over_hold: digit=%h stb=%0d want 0 1", digit, s);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        key[0] = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        n_checks++;
        if (digit !== 4'h0 || digit_stb !== 1'b0 || ledr[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: digit=%h stb=%b led4=%b", digit, digit_stb, ledr[4]);
        end
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            n_checks++;
            if (digit !== ((e >= 7) ? 4'h1 : 4'h0) || digit_stb !== (e == 7)) begin
                n_fail++;
                $display("FAIL post_reset e%0d: digit=%h stb=%b", e, digit, digit_stb);
            end
        end
        key[0] = 1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        int hold_len = 0;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_checks++;
            if ({digit, digit_stb, ledr} !== {m_digit, m_stb, m_ledr}) begin
                n_fail++;
                $display("FAIL random c%0d: got %h/%b/%h want %h/%b/%h",
                         c, digit, digit_stb, ledr, m_digit, m_stb, m_ledr);
            end
            rst = ($urandom_range(0, 199) == 0);
            if (hold_len == 0) begin
                key = 4'($urandom);
                if ($urandom_range(0, 1) == 1) key[3] = 1;
                hold_len = $urandom_range(1, 12);
            end else begin
                hold_len--;
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_wrap();
        test_cancel_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_digit_counter.md
KEY_DIGIT_COUNTER -- requirements
Module: key_digit_counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the consecutive-cycle count a key level must hold to be accepted (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 CLOCK_50  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 KEY  input  4  SHALL be the raw active-low push-buttons: [0] increment, [1] decrement, [2] clear, [3] hold (level).
REQ-005 DIGIT  output  4  SHALL be the current hex digit (0x0-0xF), intended to drive the downstream 7-segment decoder directly.
REQ-006 DIGIT_STB  output  1  SHALL pulse high for one cycle after every accepted DIGIT update.
REQ-007 LEDR  output  10  SHALL be the status LEDs: [3:0]=DIGIT, [7:4]=debounced pressed levels of KEY[3:0] (1=pressed), [8]=sticky wrap flag, [9]=0.

Function
REQ-008 Each KEY bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-009 Each key SHALL have an independent debouncer: stable level plus counter; a counter increments on every edge where synchronized level != stable level, and clears on any edge where they match.
REQ-010 A debouncer SHALL flip its stable level on the DEBOUNCE_CYCLES-th consecutive mismatching edge and clear its counter on that same edge.
REQ-011 A press event SHALL be a stable-level 1->0 transition (registered edge detect); releases generate no event.
REQ-012 Latency: with KEY changing before edge 1 and held, DIGIT SHALL update on edge DEBOUNCE_CYCLES+3 and DIGIT_STB SHALL be high for exactly the following cycle.
REQ-013 Any glitch shorter than DEBOUNCE_CYCLES cycles (post-synchronizer) SHALL produce no event.
REQ-014 Per-cycle priority SHALL be: clear > hold > increment/decrement.
REQ-015 Clear press event: DIGIT<=0, LEDR[8]<=0, DIGIT_STB asserts even if DIGIT was already 0.
REQ-016 While debounced KEY[3] is pressed, increment/decrement events SHALL be discarded (not queued), with no strobe.
REQ-017 Increment: DIGIT<=DIGIT+1 modulo 16; 0xF->0x0 SHALL set LEDR[8].
REQ-018 Decrement: DIGIT<=DIGIT-1 modulo 16; 0x0->0xF SHALL set LEDR[8].
REQ-019 Increment and decrement events in the same cycle SHALL cancel: DIGIT unchanged, no strobe, LEDR[8] unchanged.
REQ-020 LEDR[8] SHALL remain set until clear event or RESET.
REQ-021 Holding a key SHALL produce exactly one event; no auto-repeat.
REQ-022 DIGIT SHALL change only on accepted events; DIGIT_STB SHALL never assert for two consecutive cycles from a single event.

Reset
REQ-023 While RESET is high at a clock edge: synchronizer flops and stable levels <=1 (released), debounce counters <=0, edge-detect history <=1, DIGIT<=0, DIGIT_STB<=0, LEDR[8]<=0.
REQ-024 RESET asserted mid-debounce SHALL discard the pending transition; a key still held low after release of RESET SHALL be accepted as a fresh press after full latency.
REQ-025 RESET SHALL override all key activity in the same cycle; outputs SHALL read reset values on the cycle after the first reset edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset, then KEY[0] low held from before edge 1 -> DIGIT 0x0->0x1 on edge 7, DIGIT_STB high one cycle, LEDR[3:0]=0001, LEDR[4]=1.
REQ-027 KEY[0] low for 3 cycles then high -> no event, DIGIT stays 0x0, DIGIT_STB never asserts.
REQ-028 DIGIT=0xF, increment press -> DIGIT=0x0, LEDR[8]=1; then KEY[1] press -> DIGIT=0xF, LEDR[8] stays 1; then KEY[2] press -> DIGIT=0x0, LEDR[8]=0, strobe asserted.
REQ-029 KEY[0] and KEY[1] falling in same cycle from DIGIT=0x5 -> DIGIT stays 0x5, no strobe; KEY[3] held then KEY[0] press -> DIGIT stays 0x5, and on KEY[3] release no delayed increment.
REQ-030 KEY[0] low, RESET pulsed at edge 4 for one cycle, KEY[0] kept low -> no event before reset; DIGIT=0x0 after reset, then 0x1 exactly DEBOUNCE_CYCLES+3 edges after first post-reset edge.
